// File: rtl/bram_pkg.sv
// bram_pkg: shared read latency, FIFO depth and FSM encoding for the BRAM stream reader.
// Define BRAM_READER_OUTREG_EN when the BRAM is built with its output register.
package bram_pkg;
`ifdef BRAM_READER_OUTREG_EN
  localparam int READ_LATENCY = 2;
`else
  localparam int READ_LATENCY = 1;
`endif
  localparam int FIFO_DEPTH = READ_LATENCY + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic logic [CNT_W-1:0] popcount(input logic [READ_LATENCY-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < READ_LATENCY; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/bram_reader_fifo.sv
// bram_reader_fifo: small first-word-fall-through FIFO absorbing BRAM read data under backpressure.
module bram_reader_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 8,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  assign w_pop = i_pop && r_count != '0;
  assign w_push = i_push && (r_count != CW'(DEPTH) || w_pop);
  assign o_data = r_mem[r_rd];
  assign o_count = r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_mem[r_wr] <= i_data;
      if (w_push) r_wr <= r_wr == PW'(DEPTH - 1) ? '0 : r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd == PW'(DEPTH - 1) ? '0 : r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: issues sequential BRAM reads and streams the words out over valid/ready.
// Define BRAM_READER_OUTREG_EN for a BRAM with output register (two-cycle read latency).
module bram_stream_reader import bram_pkg::*; #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);
  state_t r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0] r_remain;
  logic [READ_LATENCY-1:0] r_flags;
  logic r_done;
  logic [CNT_W-1:0] w_fifo_count, w_inflight, w_used;
  logic w_pop, w_issue, w_last_pop;
  assign w_inflight = popcount(r_flags);
  assign w_used = w_fifo_count + w_inflight;
  assign w_pop = m_valid & m_ready;
  // A pop in the same cycle frees the slot this read will eventually land in.
  assign w_issue = r_state == RUN &&
                   (w_used < CNT_W'(FIFO_DEPTH) || (w_used == CNT_W'(FIFO_DEPTH) && w_pop));
  assign w_last_pop = w_inflight == '0 &&
                      (w_fifo_count == '0 || (w_fifo_count == CNT_W'(1) && w_pop));
  assign busy = r_state != IDLE;
  assign done = r_done;
  assign bram_we = 1'b0;
  assign bram_addr = r_addr;
  assign m_valid = w_fifo_count != '0;
  bram_reader_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_WIDTH), .CW(CNT_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .i_push(r_flags[READ_LATENCY-1]),
    .i_pop(w_pop),
    .i_data(bram_rdata),
    .o_data(m_data),
    .o_count(w_fifo_count)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_remain <= '0;
      r_flags <= '0;
      r_done <= 1'b0;
    end else begin
      r_flags <= READ_LATENCY'({r_flags, w_issue});
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          if (length == '0) r_done <= 1'b1;
          else begin
            r_addr <= base_addr;
            r_remain <= length;
            r_state <= RUN;
          end
        end
        RUN: if (w_issue) begin
          r_addr <= r_addr + 1'b1;
          r_remain <= r_remain - 1'b1;
          if (r_remain == (ADDR_WIDTH+1)'(1)) r_state <= DRAIN;
        end
        DRAIN: if (w_last_pop) begin
          r_done <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
